// File: rtl/dmem_controller_if.sv
// rtl/dmem_controller_if.sv - request/response and memory-side bundle for dmem_controller
//
// Port summary (directions as seen by the controller, modport slave):
//   init_done                          out  zero-fill complete
//   pN_valid/pN_write/pN_addr/pN_wdata in   request from port N (0 = LSU, 1 = DMA/debug)
//   pN_ready                           out  request accepted when valid & ready
//   pN_resp_valid/pN_rdata             out  one-cycle completion pulse and load data
//   mem_write/mem_addr/mem_in          out  to data_memory
//   mem_out                            in   from data_memory (combinational read)
// The master modport is the mirror image, used by requesters and the memory model.

interface dmem_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  init_done;

    logic                  p0_valid;
    logic                  p0_ready;
    logic                  p0_write;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_resp_valid;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_valid;
    logic                  p1_ready;
    logic                  p1_write;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_resp_valid;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_in;
    logic [DATA_WIDTH-1:0] mem_out;

    modport slave (
        output init_done,
        input  p0_valid, p0_write, p0_addr, p0_wdata,
        output p0_ready, p0_resp_valid, p0_rdata,
        input  p1_valid, p1_write, p1_addr, p1_wdata,
        output p1_ready, p1_resp_valid, p1_rdata,
        output mem_write, mem_addr, mem_in,
        input  mem_out
    );

    modport master (
        input  init_done,
        output p0_valid, p0_write, p0_addr, p0_wdata,
        input  p0_ready, p0_resp_valid, p0_rdata,
        output p1_valid, p1_write, p1_addr, p1_wdata,
        input  p1_ready, p1_resp_valid, p1_rdata,
        input  mem_write, mem_addr, mem_in,
        output mem_out
    );
endinterface

// File: rtl/dmem_controller.sv
// rtl/dmem_controller.sv - zero-fill sequencer and two-port arbiter in front of data_memory
//
// Ports:
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave side of dmem_controller_if (request ports 0/1, responses,
//            init_done and the data_memory write/address/data/read-data nets)
//
// After reset the first INIT_WORDS words are written with zero, one per cycle,
// then the request ports open. Accepted requests go through a two-stage pipe:
// access register A drives the memory, the response register returns data
// two cycles after the accept.

module dmem_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INIT_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_controller_if.slave  bus
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t                RESET_STATE = (INIT_WORDS == 0) ? ST_RUN : ST_INIT;
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST   = ADDR_WIDTH'(INIT_WORDS - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ic_q, ic_d;
    logic                  last_q;

    // Access register A
    logic                  a_valid_q;
    logic                  a_port_q;
    logic                  a_write_q;
    logic [ADDR_WIDTH-1:0] a_addr_q;
    logic [DATA_WIDTH-1:0] a_wdata_q;

    // Response register
    logic                  r_valid_q;
    logic                  r_port_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    // Last address/data driven to the memory, held while A is empty
    logic [ADDR_WIDTH-1:0] hold_addr_q;
    logic [DATA_WIDTH-1:0] hold_in_q;

    logic                  grant0, grant1, accept;
    logic                  drive;
    logic                  drv_write;
    logic [ADDR_WIDTH-1:0] drv_addr;
    logic [DATA_WIDTH-1:0] drv_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ic_d      = ic_q;
        grant0    = 1'b0;
        grant1    = 1'b0;
        drive     = 1'b0;
        drv_write = 1'b0;
        drv_addr  = hold_addr_q;
        drv_in    = hold_in_q;
        case (state_q)
            ST_INIT: begin
                drive     = 1'b1;
                drv_write = 1'b1;
                drv_addr  = ic_q;
                drv_in    = '0;
                ic_d      = ic_q + ADDR_WIDTH'(1);
                if (ic_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A lone requester always wins; on contention the port that
                // did not win last time goes first.
                grant0 = bus.p0_valid & (~bus.p1_valid | last_q);
                grant1 = bus.p1_valid & (~bus.p0_valid | ~last_q);
                if (a_valid_q) begin
                    drive     = 1'b1;
                    drv_write = a_write_q;
                    drv_addr  = a_addr_q;
                    drv_in    = a_wdata_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign accept = grant0 | grant1;

    // The state register sits in RUN during reset when INIT_WORDS is 0, and
    // in INIT (which asserts a write) otherwise, so ready and mem_write are
    // forced low directly from reset_n.
    assign bus.p0_ready  = reset_n & grant0;
    assign bus.p1_ready  = reset_n & grant1;
    assign bus.mem_write = reset_n & drv_write;
    assign bus.mem_addr  = drv_addr;
    assign bus.mem_in    = drv_in;
    assign bus.init_done = (state_q == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ic_q        <= '0;
            last_q      <= 1'b1;
            a_valid_q   <= 1'b0;
            a_port_q    <= 1'b0;
            a_write_q   <= 1'b0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            r_valid_q   <= 1'b0;
            r_port_q    <= 1'b0;
            r_data_q    <= '0;
            hold_addr_q <= '0;
            hold_in_q   <= '0;
        end else begin
            ic_q      <= ic_d;
            a_valid_q <= accept;
            if (accept) begin
                last_q    <= grant1;
                a_port_q  <= grant1;
                a_write_q <= grant1 ? bus.p1_write : bus.p0_write;
                a_addr_q  <= grant1 ? bus.p1_addr  : bus.p0_addr;
                a_wdata_q <= grant1 ? bus.p1_wdata : bus.p0_wdata;
            end
            r_valid_q <= a_valid_q;
            if (a_valid_q) begin
                r_port_q <= a_port_q;
                r_data_q <= a_write_q ? '0 : bus.mem_out;
            end
            if (drive) begin
                hold_addr_q <= drv_addr;
                hold_in_q   <= drv_in;
            end
        end
    end

    assign bus.p0_resp_valid = r_valid_q & ~r_port_q;
    assign bus.p1_resp_valid = r_valid_q &  r_port_q;
    assign bus.p0_rdata      = (r_valid_q & ~r_port_q) ? r_data_q : '0;
    assign bus.p1_rdata      = (r_valid_q &  r_port_q) ? r_data_q : '0;

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Sequencing and arbitration front-end for the single-port `data_memory` block. Two requesters share the memory through valid/ready request ports: port 0 is the core load/store unit and port 1 is the auxiliary DMA/debug master. After every reset the block zero-fills the first `INIT_WORDS` locations and only then opens the request ports. The `data_memory` synchronous reset input is tied inactive at the top level, so this block owns all memory clearing.

## Interface
- `ADDR_WIDTH`, 32: address width on both request ports and on the memory side.
- `DATA_WIDTH`, 32: data width.
- `INIT_WORDS`, 256: number of words zero-filled after reset, starting at address 0. A value of 0 skips the INIT state. Requires `INIT_WORDS <= 2**ADDR_WIDTH`.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `init_done` out 1: high once the zero-fill is complete.
- `p0_valid`, `p1_valid` in 1: request valid.
- `p0_ready`, `p1_ready` out 1: request accepted when both valid and ready are high.
- `p0_write`, `p1_write` in 1: 1 = store, 0 = load.
- `p0_addr`, `p1_addr` in ADDR_WIDTH: word address.
- `p0_wdata`, `p1_wdata` in DATA_WIDTH: store data.
- `p0_resp_valid`, `p1_resp_valid` out 1: one-cycle completion pulse, issued for both loads and stores.
- `p0_rdata`, `p1_rdata` out DATA_WIDTH: load data, valid while the matching `resp_valid` is high; 0 for stores.
- `mem_write` out 1: drives `data_memory.mem_write`.
- `mem_addr` out ADDR_WIDTH: drives `data_memory.mem_addr`.
- `mem_in` out DATA_WIDTH: drives `data_memory.mem_in`.
- `mem_out` in DATA_WIDTH: connects to `data_memory.mem_out` (combinational read).

## Operation
- States: INIT and RUN. Reset enters INIT, or RUN directly if `INIT_WORDS==0`.
- **INIT:**
  - Init counter `ic` starts at 0.
  - Each cycle drives `mem_write=1`, `mem_addr=ic`, `mem_in=0`, then increments `ic`.
  - On the edge that writes address `INIT_WORDS-1`, the state moves to RUN and `init_done` goes to 1.
  - Both `pN_ready` outputs are held at 0 throughout INIT.
- **RUN, arbitration:**
  - A 1-bit `last` register records the most recently granted port. Its reset value is 1, so port 0 wins the first contest.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port != `last` is granted.
  - `pN_ready` = RUN and grant N. Ready is combinational from valids and may depend on the other port's valid.
  - On a handshake, `last` updates to the granted port.
  - At most one request is accepted per cycle. There are no bubbles between back-to-back requests.
- **Pipeline:**
  - Accept (cycle N): the request is latched into access register A (valid, port id, write, addr, wdata).
  - Access (cycle N+1): A drives `mem_addr`/`mem_in`, and `mem_write = A.valid & A.write`. For a load, `mem_out` is captured into the response register at the end of this cycle. A store commits to memory at that same edge.
  - Response (cycle N+2): the matching `pN_resp_valid` is high for exactly one cycle. `pN_rdata` carries the load data or 0; the other port's `rdata` is 0.
- When A is empty in RUN: `mem_write=0`, and `mem_addr`/`mem_in` hold their last values.
- Responses have no backpressure; requesters must always sink them.
- Read-after-write to the same address on consecutive accepts returns the new data, because the store commits before the load's access cycle.
- Out-of-range addresses are passed through unchanged.

## Timing
- Reset values (asynchronous, while `reset_n=0`):
  - `init_done = (INIT_WORDS==0)`.
  - `pN_ready=0`, `pN_resp_valid=0`, `pN_rdata=0`.
  - `mem_write=0`, `mem_addr=0`, `mem_in=0`.
  - A empty, `ic=0`, `last=1`.
- Request-to-response latency is exactly 2 cycles. Throughput is 1 request per cycle, summed across ports.
- First RUN cycle, and first possible accept, is cycle `INIT_WORDS` after reset release.
- Asserting `reset_n` low mid-operation:
  - In-flight requests in A or in the response register are dropped and no `resp_valid` is issued for them.
  - A store that has not reached its commit edge is not written.
  - The FSM restarts INIT from address 0.
- With both ports valid in every cycle, grants strictly alternate.

## Test plan
- `INIT_WORDS=4`, release reset → `mem_write=1` with `mem_addr` 0,1,2,3 and `mem_in=0` in cycles 0–3. `init_done=1` and `p0_ready=1` (with `p0_valid` held high) from cycle 4; both readies are 0 before that.
- p0 store 0x10←0xDEADBEEF accepted at N, p0 load 0x10 accepted at N+1 → `p0_resp_valid` at N+2 with `rdata=0`, and at N+3 with `rdata=0xDEADBEEF`.
- Both ports valid for 4 cycles from the first RUN cycle → grants 0,1,0,1. Responses alternate on p0/p1 two cycles later, and `p1_ready=0` on p0 grant cycles.
- Only p1 valid for 3 consecutive cycles, loading addresses 1,2,3 → 3 accepts, 3 consecutive `p1_resp_valid` pulses with the stored data. `p0_resp_valid` stays 0.
- p0 store accepted at N, `reset_n` low during N+1 before the edge → no `p0_resp_valid`, INIT restarts at address 0. A load of that address after INIT returns 0 (when the address is < `INIT_WORDS`).
- Load of address 5 after a fresh INIT, with prior garbage in memory → `rdata=0`.
